// File: rtl/pulse_cmd_sender.sv
// Serialises one command (8-bit control + 32-bit value) as a 5-byte UART frame and checks the echoed checksum.
// Define PULSE_CMD_TIMEOUT_EN to add the echo timeout counter; otherwise WAIT_ACK waits indefinitely.
module pulse_cmd_sender #(
    parameter logic [23:0] ACK_TIMEOUT = 24'd2_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [7:0]  cmd_ctrl,
    input  logic [31:0] cmd_data,
    output logic        transmit,
    output logic [7:0]  tx_byte,
    input  logic        is_transmitting,
    input  logic        received,
    input  logic [7:0]  rx_byte,
    input  logic        recv_error,
    output logic        busy,
    output logic        done,
    output logic        ack_ok,
    output logic        ack_timeout,
    output logic [7:0]  ack_byte
);
    localparam int unsigned IDX_W = 3;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(4);

    typedef enum logic [2:0] {IDLE, SEND, HOLD, DRAIN, WAIT_ACK} state_t;

    state_t           state, state_nx;
    logic [IDX_W-1:0] idx, idx_nx;
    logic [31:0]      data_q;
    logic [7:0]       ctrl_q;
    logic [7:0]       expected;
    logic [7:0]       frame_byte;
    logic             accept;
    logic             enter_wait;
    logic             timeout_hit;
    logic             done_nx;
    logic             ack_ok_nx;
    logic             ack_timeout_nx;
    logic [7:0]       ack_byte_nx;

    assign cmd_ready  = (state == IDLE);
    assign busy       = (state != IDLE);
    assign accept     = cmd_valid & cmd_ready;
    assign enter_wait = (state == DRAIN) && (state_nx == WAIT_ACK);

    // Frame order: value bytes LSB first, control byte last
    always_comb begin
        case (idx)
            IDX_W'(0): frame_byte = data_q[7:0];
            IDX_W'(1): frame_byte = data_q[15:8];
            IDX_W'(2): frame_byte = data_q[23:16];
            IDX_W'(3): frame_byte = data_q[31:24];
            default:   frame_byte = ctrl_q;
        endcase
    end

`ifdef PULSE_CMD_TIMEOUT_EN
    localparam int unsigned CNT_W  = 24;
    localparam int unsigned CNTX_W = CNT_W + 1;

    logic [CNT_W-1:0] wait_cnt;

    // Saturating count of WAIT_ACK cycles, cleared on entry
    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt <= '0;
        end else if (enter_wait) begin
            wait_cnt <= '0;
        end else if ((state == WAIT_ACK) && (wait_cnt != {CNT_W{1'b1}})) begin
            wait_cnt <= wait_cnt + CNT_W'(1);
        end
    end

    // Fires in the cycle whose increment brings the count to ACK_TIMEOUT
    assign timeout_hit = (CNTX_W'(wait_cnt) + CNTX_W'(1)) >= CNTX_W'(ACK_TIMEOUT);
`else
    assign timeout_hit = 1'b0 & (ACK_TIMEOUT != '0);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx       = state;
        idx_nx         = idx;
        transmit       = 1'b0;
        tx_byte        = '0;
        done_nx        = 1'b0;
        ack_ok_nx      = ack_ok;
        ack_timeout_nx = ack_timeout;
        ack_byte_nx    = ack_byte;
        case (state)
            IDLE: begin
                if (cmd_valid) begin
                    state_nx = SEND;
                    idx_nx   = '0;
                end
            end
            SEND: begin
                if (!is_transmitting) begin
                    transmit = 1'b1;
                    tx_byte  = frame_byte;
                    state_nx = HOLD;
                end
            end
            // HOLD keeps is_transmitting from being judged in the strobe cycle
            HOLD: state_nx = DRAIN;
            DRAIN: begin
                if (!is_transmitting) begin
                    if (idx == LAST_IDX) begin
                        state_nx = WAIT_ACK;
                    end else begin
                        idx_nx   = idx + IDX_W'(1);
                        state_nx = SEND;
                    end
                end
            end
            WAIT_ACK: begin
                if (received) begin
                    ack_byte_nx    = rx_byte;
                    ack_ok_nx      = (rx_byte == expected);
                    ack_timeout_nx = 1'b0;
                    done_nx        = 1'b1;
                    state_nx       = IDLE;
                end else if (recv_error) begin
                    ack_ok_nx      = 1'b0;
                    ack_timeout_nx = 1'b0;
                    done_nx        = 1'b1;
                    state_nx       = IDLE;
                end else if (timeout_hit) begin
                    ack_ok_nx      = 1'b0;
                    ack_timeout_nx = 1'b1;
                    done_nx        = 1'b1;
                    state_nx       = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Command latch, byte index and status registers
    always_ff @(posedge clk) begin
        if (rst) begin
            idx         <= '0;
            data_q      <= '0;
            ctrl_q      <= '0;
            expected    <= '0;
            done        <= 1'b0;
            ack_ok      <= 1'b0;
            ack_timeout <= 1'b0;
            ack_byte    <= '0;
        end else begin
            idx         <= idx_nx;
            done        <= done_nx;
            ack_ok      <= ack_ok_nx;
            ack_timeout <= ack_timeout_nx;
            ack_byte    <= ack_byte_nx;
            if (accept) begin
                data_q   <= cmd_data;
                ctrl_q   <= cmd_ctrl;
                expected <= cmd_data[7:0] + cmd_data[15:8] + cmd_data[23:16] + cmd_data[31:24];
            end
        end
    end

endmodule

// File: doc/pulse_cmd_sender.md
# pulse_cmd_sender

Host-side command transmitter for the pulse-parameter UART link. Accepts one command (8-bit control code plus 32-bit value) on a valid/ready interface and serialises it as a 5-byte frame through the shared `uart` byte interface. The frame is the 4 value bytes, least-significant first, followed by the control byte. It then waits for the single checksum byte the pulse controller echoes back, and reports match, mismatch or timeout. It sits in front of a `uart` instance in sequencer or test-harness designs that reprogram a remote pulse controller.

## Interface
- `ACK_TIMEOUT`, default 24'd2_000_000: cycles to wait for the echo byte after the last frame byte finishes transmitting.
- `clk`  in  1  system clock.
- `rst`  in  1  synchronous, active-high reset.
- `cmd_valid`  in  1  command offered.
- `cmd_ready`  out  1  high only in IDLE.
- `cmd_ctrl`  in  8  control code (0 delay, 1 period, 2 pulse1, 3 pulse2, 4 toggle, 5 cpmg, 7 nutw, 8 nutd, 9 nut).
- `cmd_data`  in  32  parameter value.
- `transmit`  out  1  one-cycle send strobe to `uart`.
- `tx_byte`  out  8  byte to `uart`.
- `is_transmitting`  in  1  from `uart`.
- `received`  in  1  from `uart`, one-cycle strobe.
- `rx_byte`  in  8  from `uart`.
- `recv_error`  in  1  from `uart`.
- `busy`  out  1  high in any state except IDLE.
- `done`  out  1  one-cycle completion strobe.
- `ack_ok`  out  1  last echo equalled the expected checksum.
- `ack_timeout`  out  1  last command ended without an echo.
- `ack_byte`  out  8  last echo byte received; holds its previous value on timeout.

## Operation
- Handshake: a command is accepted in a cycle where `cmd_valid & cmd_ready`. On acceptance, `cmd_ctrl` and `cmd_data` are latched, and `expected = d[7:0]+d[15:8]+d[23:16]+d[31:24]` is computed modulo 256.
- States:
  - IDLE: waits for a command.
  - SEND: drives byte index 0–4.
  - HOLD: one cycle, `transmit=0`.
  - DRAIN: waits for `is_transmitting==0`.
  - WAIT_ACK: waits for the echo.
- SEND: if `is_transmitting==0`, assert `transmit=1` and `tx_byte=frame[idx]`, then go to HOLD. Otherwise stall in SEND.
- HOLD → DRAIN. DRAIN: when `is_transmitting==0`, go to SEND with idx+1 if idx<4, otherwise go to WAIT_ACK with the timeout counter cleared.
- Frame order: `d[7:0]`, `d[15:8]`, `d[23:16]`, `d[31:24]`, then `ctrl`.
- WAIT_ACK:
  - On `received`: `ack_byte<=rx_byte`, `ack_ok<=(rx_byte==expected)`, `ack_timeout<=0`, pulse `done`, go to IDLE.
  - `recv_error` in WAIT_ACK: `ack_ok<=0`, `ack_timeout<=0`, pulse `done`, go to IDLE.
- `received` and `recv_error` outside WAIT_ACK are ignored. `cmd_valid` while busy is ignored (not queued).
- `ack_ok`, `ack_timeout` and `ack_byte` hold their values until the next `done`.

## Timing
- Reset values: state IDLE, `cmd_ready=1`, `busy=0`, `transmit=0`, `tx_byte=0`, `done=0`, `ack_ok=0`, `ack_timeout=0`, `ack_byte=0`, idx=0, counter=0.
- Acceptance in cycle T:
  - `busy=1`, `cmd_ready=0` from T+1.
  - First `transmit` at T+1 if `is_transmitting==0`.
- Each byte occupies 1 SEND + 1 HOLD + ≥1 DRAIN cycles plus the UART frame time. HOLD guarantees `is_transmitting` is not sampled in the same cycle as the strobe.
- `done`, new status and `cmd_ready=1` all appear in the cycle after the `received` strobe. A new command may be accepted in that same cycle.
- Reset mid-frame:
  - `transmit` deasserts in the next cycle and the block returns to IDLE.
  - A byte already handed to `uart` completes.
  - The remote end is left mid-frame; recovering it is the caller's responsibility (send filler bytes).
- Timeout counter: 24 bits, saturating, increments once per WAIT_ACK cycle.

## Configuration
- `PULSE_CMD_TIMEOUT_EN` defined:
  - If the counter reaches `ACK_TIMEOUT` in WAIT_ACK without `received`: `ack_timeout<=1`, `ack_ok<=0`, pulse `done`, go to IDLE.
  - `received` in the same cycle the counter reaches `ACK_TIMEOUT` wins: it is treated as a normal echo.
- `PULSE_CMD_TIMEOUT_EN` undefined: no counter is synthesised, WAIT_ACK waits indefinitely, and `ack_timeout` is tied to 0.

## Test plan
- `cmd_ctrl=0x00`, `cmd_data=0x000000C8`, UART model echoes 0xC8 → tx bytes C8,00,00,00,00, then `done` with `ack_ok=1`, `ack_byte=0xC8`.
- `cmd_ctrl=0x02`, `cmd_data=0x01020304`, echo 0x0B → bytes 04,03,02,01,02; expected 0x0A; `done`, `ack_ok=0`, `ack_byte=0x0B`.
- Checksum wrap: `cmd_data=0xFFFFFFFF`, echo 0xFC → `ack_ok=1`.
- `PULSE_CMD_TIMEOUT_EN`, `ACK_TIMEOUT=100`, no echo → `done` exactly 100 WAIT_ACK cycles after the final DRAIN exit, `ack_timeout=1`. Stray `received` in IDLE afterwards → no `done`.
- `rst` asserted while byte 2 is in SEND/DRAIN → next cycle `transmit=0`, `busy=0`, `cmd_ready=1`, all status outputs 0. `cmd_valid` asserted during busy → no second frame.
- `is_transmitting` held high for 50 cycles at SEND → `transmit` stays 0 until it falls, then a single strobe.
